timer_seq_master: RTL and testbench

AXI4-Lite master that sequences one timer run on the timer's AXI4-Lite register slave: writes LOAD, writes CTRL.start, polls STATUS.expired, then reports completion. It sits between a simple command interface (CPU-less control logic or a test sequencer) and the timer's AXI4-Lite slave. It owns the bus alone; no other master shares the port.

---
 rtl/timer_seq_master.sv | 132 +++++++++++++
 tb/tb_timer_seq_master.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_seq_master.sv
// timer_seq_master: AXI4-Lite master that loads and starts the timer, polls STATUS.expired and reports the outcome.
// One write or read engine is active at a time, and every AXI output comes straight from a flop.
module timer_seq_master #(
    parameter int POLL_GAP  = 4,
    parameter int MAX_POLLS = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    input  logic [31:0] cmd_load,
    output logic        cmd_ready,
    input  logic        cmd_abort,
    output logic        busy,
    output logic        done,
    output logic [1:0]  status_code,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready
);
    localparam int PW = (MAX_POLLS == 0) ? 1 : $clog2(MAX_POLLS + 1);
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WR_LOAD   = 3'd1;
    localparam logic [2:0] ST_WR_START  = 3'd2;
    localparam logic [2:0] ST_GAP       = 3'd3;
    localparam logic [2:0] ST_RD_STATUS = 3'd4;
    localparam logic [2:0] ST_WR_STOP   = 3'd5;
    localparam logic [2:0] ST_DONE      = 3'd6;

    logic [2:0]    state, nxt;
    logic [PW-1:0] poll_cnt;
    logic [31:0]   gap_cnt;
    logic [1:0]    code_q, nxt_code;
    logic          abort_q, abort_req, abort_eff, b_hs, r_hs, timeout, gap_end, unused_rdata;

    assign cmd_ready    = state == ST_IDLE;
    assign busy         = !cmd_ready;
    assign done         = state == ST_DONE;
    assign b_hs         = bready && bvalid;
    assign r_hs         = rready && rvalid;
    assign abort_req    = cmd_abort && (state == ST_WR_LOAD || state == ST_WR_START ||
                                         state == ST_RD_STATUS || state == ST_GAP);
    assign abort_eff    = abort_q || abort_req;
    assign timeout      = (MAX_POLLS != 0) && (32'(poll_cnt) + 32'd1 == 32'(MAX_POLLS));
    assign gap_end      = (gap_cnt + 32'd1) >= 32'(POLL_GAP);
    assign unused_rdata = ^rdata[31:1];
    // Expired outranks abort, which outranks timeout, at the R handshake.
    assign nxt_code     = (state == ST_WR_STOP) ? code_q :
                          (state == ST_RD_STATUS && rdata[0]) ? 2'b00 :
                          abort_eff ? 2'b10 : 2'b01;

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:      nxt = cmd_valid ? ST_WR_LOAD : ST_IDLE;
            ST_WR_LOAD:   nxt = !b_hs ? state : abort_eff ? ST_WR_STOP : ST_WR_START;
            ST_WR_START:  nxt = !b_hs ? state : abort_eff ? ST_WR_STOP : ST_RD_STATUS;
            ST_RD_STATUS: nxt = !r_hs ? state : rdata[0] ? ST_DONE :
                                (abort_eff || timeout) ? ST_WR_STOP : ST_GAP;
            ST_GAP:       nxt = abort_eff ? ST_WR_STOP : gap_end ? ST_RD_STATUS : ST_GAP;
            ST_WR_STOP:   nxt = b_hs ? ST_DONE : state;
            ST_DONE:      nxt = ST_IDLE;
            default:      nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            poll_cnt    <= '0;
            gap_cnt     <= '0;
            code_q      <= 2'b00;
            status_code <= 2'b00;
            abort_q     <= 1'b0;
            awaddr      <= '0;
            awvalid     <= 1'b0;
            wdata       <= '0;
            wvalid      <= 1'b0;
            bready      <= 1'b0;
            araddr      <= '0;
            arvalid     <= 1'b0;
            rready      <= 1'b0;
        end else begin
            state   <= nxt;
            abort_q <= (state == ST_IDLE) ? 1'b0 : abort_eff;
            gap_cnt <= (state == ST_GAP) ? gap_cnt + 32'd1 : 32'd0;
            if (state == ST_IDLE && cmd_valid)
                poll_cnt <= '0;
            else if (r_hs && !(&poll_cnt))
                poll_cnt <= poll_cnt + 1'b1;
            if (awvalid && awready) begin
                awvalid <= 1'b0;
                wvalid  <= 1'b1;
            end
            if (wvalid && wready) begin
                wvalid <= 1'b0;
                bready <= 1'b1;
            end
            if (b_hs)
                bready <= 1'b0;
            if (arvalid && arready) begin
                arvalid <= 1'b0;
                rready  <= 1'b1;
            end
            if (r_hs)
                rready <= 1'b0;
            if (nxt != state && (nxt == ST_WR_LOAD || nxt == ST_WR_START || nxt == ST_WR_STOP)) begin
                awvalid <= 1'b1;
                awaddr  <= (nxt == ST_WR_LOAD) ? 32'h0 : 32'h4;
                wdata   <= (nxt == ST_WR_LOAD) ? cmd_load : (nxt == ST_WR_START) ? 32'h1 : 32'h2;
            end
            if (nxt != state && nxt == ST_RD_STATUS) begin
                arvalid <= 1'b1;
                araddr  <= 32'h8;
            end
            if (nxt != state && nxt == ST_WR_STOP)
                code_q <= nxt_code;
            if (nxt != state && nxt == ST_DONE)
                status_code <= nxt_code;
        end
    end
endmodule

// File: tb/tb_timer_seq_master.sv
// tb_timer_seq_master: directed and randomized timer runs against a randomly stalling AXI4-Lite slave,
// comparing the observed bus traffic and status with a transaction-level reference of each run.
module tb_timer_seq_master;
    localparam int GAP  = 4;
    localparam int MAXP = 3;

    typedef struct packed {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_abort = 1'b0;
    logic [31:0] cmd_load = '0;
    logic        cmd_ready, busy, done;
    logic [1:0]  status_code;
    logic [31:0] awaddr, wdata, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [31:0] rdata = '0;

    txn_t        log_q[$], exp_q[$];
    logic [31:0] aw_q[$];
    int          errors = 0, checks = 0, ncyc = 0, last_hs = 0, first_ar = 0, rd_cnt = 0;
    int          exp_at = 0, maxd = 0, r_hs_neg = 0;
    int          aw_d, w_d, b_d, ar_d, r_d;
    bit          stall_aw = 0, stall_w = 0, r_seen = 0, r_val = 0;
    bit          aw_w, w_w, b_w, ar_w, r_w, b_pend, r_pend, p_aw, p_w, p_ar;
    logic [31:0] p_awaddr, p_wdata, p_araddr;

    timer_seq_master #(.POLL_GAP(GAP), .MAX_POLLS(MAXP)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_load(cmd_load),
        .cmd_ready(cmd_ready), .cmd_abort(cmd_abort), .busy(busy), .done(done),
        .status_code(status_code), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready), .rdata(rdata),
        .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave: decides readies at the falling edge, so any ready/valid pair seen here handshakes at the next rise.
    initial forever begin
        @(negedge clk);
        ncyc++;
        if (!reset_n) begin
            {awready, wready, bvalid, arready, rvalid} = '0;
            rdata = '0;
            {aw_w, w_w, b_w, ar_w, r_w, b_pend, r_pend, p_aw, p_w, p_ar} = '0;
            aw_q.delete();
        end else begin
            if (p_aw) chk("aw_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
            if (p_w)  chk("w_hold", {wvalid, wdata}, {1'b1, p_wdata});
            if (p_ar) chk("ar_hold", {arvalid, araddr}, {1'b1, p_araddr});
            if (awvalid || wvalid) chk("aw_w_overlap", awvalid && wvalid, 0);
            bvalid = 1'b0;
            if (b_pend) begin
                if (!b_w) begin b_w = 1; b_d = int'($urandom_range(maxd, 0)); end
                if (b_d == 0) bvalid = 1'b1; else b_d--;
            end
            if (bvalid && bready) begin b_pend = 0; b_w = 0; last_hs = ncyc; end
            rvalid = 1'b0;
            if (r_pend) begin
                if (!r_w) begin r_w = 1; r_d = int'($urandom_range(maxd, 0)); end
                if (r_d == 0) begin rvalid = 1'b1; rdata = {31'b0, r_val}; end else r_d--;
            end
            if (rvalid && rready) begin
                r_pend = 0; r_w = 0; last_hs = ncyc; r_hs_neg = ncyc; r_seen = 1;
            end
            awready = 1'b0;
            if (awvalid) begin
                if (!aw_w) begin
                    aw_w = 1;
                    aw_d = (stall_aw && awaddr == 32'h4 && wdata == 32'h1) ? 5 : int'($urandom_range(maxd, 0));
                end
                if (aw_d == 0) awready = 1'b1; else aw_d--;
            end
            if (awvalid && awready) begin aw_w = 0; aw_q.push_back(awaddr); last_hs = ncyc; end
            p_aw = awvalid && !awready;
            p_awaddr = awaddr;
            wready = 1'b0;
            if (wvalid) begin
                if (!w_w) begin w_w = 1; w_d = stall_w ? 8 : int'($urandom_range(maxd, 0)); end
                if (w_d == 0) wready = 1'b1; else w_d--;
            end
            if (wvalid && wready) begin
                w_w = 0;
                chk("aw_before_w", aw_q.size() != 0, 1);
                if (aw_q.size() != 0) log_q.push_back(txn_t'({1'b0, aw_q.pop_front(), wdata}));
                b_pend = 1;
                last_hs = ncyc;
            end
            p_w = wvalid && !wready;
            p_wdata = wdata;
            arready = 1'b0;
            if (arvalid) begin
                if (!ar_w) begin
                    ar_w = 1;
                    if (r_seen) chk("poll_gap", ncyc - r_hs_neg, GAP + 1);
                    ar_d = int'($urandom_range(maxd, 0));
                end
                if (ar_d == 0) arready = 1'b1; else ar_d--;
            end
            if (arvalid && arready) begin
                ar_w = 0;
                rd_cnt++;
                if (rd_cnt == 1) first_ar = ncyc;
                r_val = (exp_at != 0) && (rd_cnt >= exp_at);
                log_q.push_back(txn_t'({1'b1, araddr, {31'b0, r_val}}));
                r_pend = 1;
                last_hs = ncyc;
            end
            p_ar = arvalid && !arready;
            p_araddr = araddr;
        end
    end

    // mode 0: plain run, 1: abort pulse while the start write's AW stalls, 2: abort held from the 3rd AR on.
    task automatic run(input logic [31:0] load, input int ea, input int mode);
        int n, np, acc;
        bit pulsed;
        logic [1:0] es;
        exp_at = ea; rd_cnt = 0; r_seen = 0; stall_aw = (mode == 1);
        log_q.delete();
        exp_q.delete();
        exp_q.push_back(txn_t'({1'b0, 32'h0, load}));
        exp_q.push_back(txn_t'({1'b0, 32'h4, 32'h1}));
        if (mode == 1) begin
            exp_q.push_back(txn_t'({1'b0, 32'h4, 32'h2}));
            es = 2'b10;
        end else begin
            np = (ea != 0 && ea <= MAXP) ? ea : MAXP;
            for (int i = 1; i <= np; i++)
                exp_q.push_back(txn_t'({1'b1, 32'h8, 31'b0, (ea != 0 && i >= ea)}));
            if (np == ea) es = 2'b00;
            else begin
                exp_q.push_back(txn_t'({1'b0, 32'h4, 32'h2}));
                es = 2'b01;
            end
        end
        chk("ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_load = load; acc = ncyc;
        @(negedge clk); #2;
        cmd_valid = 1'b0; cmd_load = $urandom;
        chk("accept", {cmd_ready, busy}, 2'b01);
        n = 0; pulsed = 0;
        while (!done && n < 3000) begin
            if (mode == 1) begin
                cmd_abort = !pulsed && awvalid && awaddr == 32'h4 && wdata == 32'h1;
                if (cmd_abort) pulsed = 1;
            end
            if (mode == 2 && rd_cnt == 3) cmd_abort = 1'b1;
            @(negedge clk); #2;
            n++;
        end
        chk("done_seen", done, 1);
        chk("status", status_code, es);
        chk("done_lat", ncyc - last_hs, 1);
        if (mode == 0 && maxd == 0) chk("ar_lat", first_ar - acc, 7);
        chk("txn_count", log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            chk($sformatf("txn%0d", i), log_q[i], exp_q[i]);
        cmd_abort = 1'b0;
        @(negedge clk); #2;
        chk("done_pulse", {done, busy, cmd_ready}, 3'b001);
    endtask

    initial begin
        int n, m, ea;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
        chk("rst_data", {awaddr, wdata}, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_flags", {cmd_ready, busy, done, status_code}, 5'b10000);
        reset_n = 1'b1;
        @(negedge clk); #2;
        chk("ready_after_rst", cmd_ready, 1);
        maxd = 0;
        run(32'd5, 3, 0);
        run(32'h1234, 2, 0);
        run(32'd7, 0, 0);
        run(32'd9, 0, 1);
        run(32'd11, 3, 2);
        stall_w = 1;
        cmd_valid = 1'b1; cmd_load = 32'hdead;
        @(negedge clk); #2;
        cmd_valid = 1'b0;
        n = 0;
        while (!wvalid && n < 50) begin @(negedge clk); #2; n++; end
        chk("w_phase", {wvalid, awaddr}, {1'b1, 32'h0});
        reset_n = 1'b0;
        #1;
        chk("async_rst", {awvalid, wvalid, bready, arvalid, rready, busy}, 0);
        chk("rst_ready", cmd_ready, 1);
        repeat (2) @(negedge clk);
        #2;
        stall_w = 0;
        reset_n = 1'b1;
        @(negedge clk); #2;
        chk("ready_after_rst2", cmd_ready, 1);
        run(32'd21, 1, 0);
        maxd = 3;
        for (int k = 0; k < 50; k++) begin
            m = int'($urandom_range(2, 0));
            ea = (m == 2) ? 3 : int'($urandom_range(4, 0));
            run($urandom, ea, m);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
